// File: rtl/dec_pkg.sv
// Shared constants and helpers for the one-hot select decoder.
package dec_pkg;

  localparam int unsigned DEC_IN_W  = 3;
  localparam int unsigned DEC_OUT_W = 1 << DEC_IN_W;

  // OUT_W must be exactly wide enough for every code of an IN_W-bit select.
  function automatic bit out_w_valid(input int unsigned in_w, input int unsigned out_w);
    return out_w == (32'd1 << in_w);
  endfunction

  // Level taken by every output bit when nothing is selected.
  function automatic logic inactive_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/onehot_decode_core.sv
// Combinational binary-to-one-hot decode with active-high enable.
module onehot_decode_core
  import dec_pkg::*;
#(
  parameter int unsigned IN_W  = DEC_IN_W,
  parameter int unsigned OUT_W = 1 << IN_W
) (
  input  logic [IN_W-1:0]  A,
  input  logic             E,
  output logic [OUT_W-1:0] dec_c
);

  // Equality compare per bit: an unknown select matches no code, so the result stays all-zero.
  always_comb begin
    dec_c = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (E && (A == IN_W'(i))) begin
        dec_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/three_to_eight_decoder.sv
// Registered (or optionally combinational) 3-to-8 one-hot select decoder
// with selectable output polarity and asynchronous active-high reset.
module three_to_eight_decoder
  import dec_pkg::*;
#(
  parameter int unsigned IN_W       = DEC_IN_W,
  parameter int unsigned OUT_W      = 1 << IN_W,
  parameter bit          REGISTERED = 1'b1,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  A,
  input  logic             E,
  output logic [OUT_W-1:0] Out
);

  localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{inactive_level(ACTIVE_LOW)}};

  logic [OUT_W-1:0] w_dec;
  logic [OUT_W-1:0] w_out_next;

  if (!out_w_valid(IN_W, OUT_W)) begin : g_bad_width
    $error("three_to_eight_decoder: OUT_W must equal 2**IN_W");
  end

  onehot_decode_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .A     (A),
    .E     (E),
    .dec_c (w_dec)
  );

  assign w_out_next = ACTIVE_LOW ? ~w_dec : w_dec;

  if (REGISTERED) begin : g_reg
    logic [OUT_W-1:0] r_out;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out <= INACTIVE;
      end else begin
        r_out <= w_out_next;
      end
    end

    assign Out = r_out;
  end else begin : g_comb
    assign Out = rst ? INACTIVE : w_out_next;
  end

  // Enabled decode of an unknown select yields the inactive pattern; surface it in simulation.
  always_comb begin : x_sel_check
    if (E) begin
      assert (!$isunknown(A))
        else $warning("three_to_eight_decoder: enabled with unknown select A");
    end
  end

endmodule

// File: tb/tb_three_to_eight_decoder.sv
// Directed, table-driven check of the select decoder in registered, active-low
// and combinational builds.
module tb_three_to_eight_decoder;

  logic       clk;
  logic       rst;
  logic [2:0] A;
  logic       E;
  logic [7:0] out_reg;
  logic [7:0] out_al;
  logic [7:0] out_comb;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] a;
    logic       e;
    logic [7:0] exp;
  } vec_t;

  three_to_eight_decoder #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b0)) dut (
    .clk (clk), .rst (rst), .A (A), .E (E), .Out (out_reg)
  );

  three_to_eight_decoder #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b1)) dut_al (
    .clk (clk), .rst (rst), .A (A), .E (E), .Out (out_al)
  );

  three_to_eight_decoder #(.REGISTERED(1'b0), .ACTIVE_LOW(1'b0)) dut_comb (
    .clk (clk), .rst (rst), .A (A), .E (E), .Out (out_comb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_onehot(input string name, input logic [7:0] act);
    n_checks++;
    if ($countones(act) > 1 || $isunknown(act)) begin
      n_fail++;
      $display("FAIL %s: got %h expected at most one bit set", name, act);
    end
  endtask

  // Waits for the next rising edge and settles just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    // Disabled sweep, starting with an unknown select.
    vecs.push_back('{3'bxxx, 1'b0, 8'h00});
    for (int i = 0; i < 8; i++) vecs.push_back('{3'(i), 1'b0, 8'h00});
    // Enabled sweep A=0..7.
    vecs.push_back('{3'd0, 1'b1, 8'h01});
    vecs.push_back('{3'd1, 1'b1, 8'h02});
    vecs.push_back('{3'd2, 1'b1, 8'h04});
    vecs.push_back('{3'd3, 1'b1, 8'h08});
    vecs.push_back('{3'd4, 1'b1, 8'h10});
    vecs.push_back('{3'd5, 1'b1, 8'h20});
    vecs.push_back('{3'd6, 1'b1, 8'h40});
    vecs.push_back('{3'd7, 1'b1, 8'h80});
    // Enable toggle on a constant select.
    vecs.push_back('{3'd3, 1'b1, 8'h08});
    vecs.push_back('{3'd3, 1'b0, 8'h00});
    vecs.push_back('{3'd3, 1'b1, 8'h08});
    // Simultaneous select and enable changes.
    vecs.push_back('{3'd7, 1'b0, 8'h00});
    vecs.push_back('{3'd0, 1'b1, 8'h01});

    rst = 1'b0;
    A   = 3'd5;
    E   = 1'b1;

    // Reset asserted between edges takes effect without a clock.
    #3 rst = 1'b1;
    #1;
    chk("reset_async", out_reg, 8'h00);
    chk("reset_async_al", out_al, 8'hFF);
    chk("reset_comb", out_comb, 8'h00);
    tick();
    chk("reset_hold", out_reg, 8'h00);
    tick();
    chk("reset_hold2", out_al, 8'hFF);
    rst = 1'b0;
    #1;
    chk("post_reset_no_edge", out_reg, 8'h00);
    tick();
    chk("post_reset_first_edge", out_reg, 8'h20);
    chk("post_reset_first_edge_al", out_al, 8'hDF);

    // Table: comb output is checked before the edge, registered ones after it.
    foreach (vecs[k]) begin
      A = vecs[k].a;
      E = vecs[k].e;
      #1;
      chk($sformatf("comb[%0d]", k), out_comb, vecs[k].exp);
      tick();
      chk($sformatf("reg[%0d]", k), out_reg, vecs[k].exp);
      chk($sformatf("al[%0d]", k), out_al, ~vecs[k].exp);
      chk_onehot($sformatf("onehot[%0d]", k), out_reg);
    end

    // Registered output holds until the edge after an input change.
    A = 3'd1;
    E = 1'b1;
    #1;
    chk("latency_before_edge", out_reg, 8'h01);
    tick();
    chk("latency_after_edge", out_reg, 8'h02);

    // Mid-stream reset pulse between edges.
    A = 3'd6;
    E = 1'b1;
    tick();
    chk("midstream_pre", out_reg, 8'h40);
    #2 rst = 1'b1;
    #1;
    chk("midstream_async", out_reg, 8'h00);
    chk("midstream_async_al", out_al, 8'hFF);
    chk("midstream_comb", out_comb, 8'h00);
    #1 rst = 1'b0;
    #1;
    chk("midstream_released_no_edge", out_reg, 8'h00);
    chk("midstream_comb_released", out_comb, 8'h40);
    tick();
    chk("midstream_reload", out_reg, 8'h40);
    chk("midstream_reload_al", out_al, 8'hBF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
